// File: rtl/posit_decoder_pkg.sv
// Shared constants and state encoding for the posit<32,3> decoder.
package posit_decoder_pkg;

  localparam int unsigned N     = 32;
  localparam int unsigned ES    = 3;
  localparam int unsigned K_W   = 6;
  localparam int unsigned RUN_W = 5;
  localparam int unsigned SHF_W = 6;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ABS     = 3'd1,
    S_REGIME  = 3'd2,
    S_EXTRACT = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  localparam logic [N-1:0] NAR  = 32'h8000_0000;
  localparam logic [N-1:0] ZERO = 32'h0000_0000;

endpackage

// File: rtl/posit_regime_counter.sv
// Combinational regime run-length counter.
// Ports: word (32-bit absolute posit word), run_len (length of the run of
// identical bits starting at bit 30), run_pol (value of the run bits).
module posit_regime_counter
  import posit_decoder_pkg::*;
(
  input  logic [N-1:0]     word,
  output logic [RUN_W-1:0] run_len,
  output logic             run_pol
);

  // Sign position is irrelevant to the regime.
  logic unused_msb;
  assign unused_msb = word[N-1];

  logic hit;

  // Count from bit 30 down until the first opposite bit.
  always_comb begin
    run_pol = word[N-2];
    run_len = '0;
    hit     = 1'b0;
    for (int i = N - 2; i >= 0; i--) begin
      if (!hit) begin
        if (word[i] == word[N-2]) begin
          run_len = run_len + RUN_W'(1);
        end else begin
          hit = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/posit_decoder.sv
// Multi-cycle posit<32,3> field decoder.
// Ports: posit_num/start (request, sampled in IDLE), clk, rst (async
// active-low), sign/k/exp_value/mantissa (decoded fields, held until the
// next accepted request), done (one-cycle pulse when fields update).
module posit_decoder
  import posit_decoder_pkg::*;
(
  input  logic [N-1:0]   posit_num,
  input  logic           start,
  input  logic           clk,
  input  logic           rst,
  output logic           sign,
  output logic           done,
  output logic [K_W-1:0] k,
  output logic [ES-1:0]  exp_value,
  output logic [N-1:0]   mantissa
);

  state_t           state, state_nxt;
  logic [N-1:0]     word;
  logic             sgn;
  logic [RUN_W-1:0] run_len_q;
  logic             run_pol_q;

  logic [RUN_W-1:0] run_len_c;
  logic             run_pol_c;
  logic [SHF_W-1:0] shamt_c;
  logic [N-1:0]     tail_c;
  logic             special_c;

  posit_regime_counter u_regime (
    .word    (word),
    .run_len (run_len_c),
    .run_pol (run_pol_c)
  );

  // Drop sign, run and terminator; shifts past 31 leave zero (no terminator).
  assign shamt_c   = SHF_W'(run_len_q) + SHF_W'(2);
  assign tail_c    = word << shamt_c;
  // After the abs stage only zero and NaR have no set bit in [30:0].
  assign special_c = (word == ZERO) || (word == NAR);

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (start) state_nxt = S_ABS;
      S_ABS:     state_nxt = S_REGIME;
      S_REGIME:  state_nxt = S_EXTRACT;
      S_EXTRACT: state_nxt = S_DONE;
      S_DONE:    state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      word      <= ZERO;
      sgn       <= 1'b0;
      run_len_q <= '0;
      run_pol_q <= 1'b0;
      sign      <= 1'b0;
      done      <= 1'b0;
      k         <= '0;
      exp_value <= '0;
      mantissa  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) word <= posit_num;
        end
        S_ABS: begin
          sgn <= word[N-1];
          if (word[N-1]) word <= ~word + N'(1);
        end
        S_REGIME: begin
          run_len_q <= run_len_c;
          run_pol_q <= run_pol_c;
        end
        S_EXTRACT: begin
          done <= 1'b1;
          sign <= sgn;
          if (special_c) begin
            k         <= '0;
            exp_value <= '0;
            mantissa  <= '0;
          end else begin
            k         <= run_pol_q ? (K_W'(run_len_q) - K_W'(1)) : (K_W'(0) - K_W'(run_len_q));
            exp_value <= tail_c[N-1 -: ES];
            mantissa  <= {1'b1, tail_c[N-ES-1:0], 2'b00};
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_posit_decoder.sv
// Self-checking bench for posit_decoder: directed corner words, reset abort,
// back-to-back operation and randomized words against an arithmetic model.
module tb_posit_decoder;

  logic [31:0] posit_num;
  logic        start;
  logic        clk;
  logic        rst;
  logic        sign;
  logic        done;
  logic [5:0]  k;
  logic [2:0]  exp_value;
  logic [31:0] mantissa;

  int checks = 0;
  int errors = 0;
  int cycle  = 0;
  int last_done = -1;

  posit_decoder dut (
    .posit_num (posit_num),
    .start     (start),
    .clk       (clk),
    .rst       (rst),
    .sign      (sign),
    .done      (done),
    .k         (k),
    .exp_value (exp_value),
    .mantissa  (mantissa)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Index of the highest set bit, -1 when none.
  function automatic int msb_of(input longint unsigned v);
    int r = -1;
    for (int i = 0; i < 64; i++) if (((v >> i) & 64'd1) != 0) r = i;
    return r;
  endfunction

  // Reference decode from the posit definition using integer arithmetic.
  function automatic void ref_model(input logic [31:0] w, output logic s,
                                    output logic [5:0] kk, output logic [2:0] e,
                                    output logic [31:0] m);
    longint unsigned a, rest, frac;
    int run, kv, r, f;
    s = w[31];
    a = s ? ((64'h1_0000_0000 - longint'(w)) & 64'hFFFF_FFFF) : longint'(w);
    a = a & 64'h7FFF_FFFF;
    if (a == 0) begin
      kk = '0; e = '0; m = '0;
      return;
    end
    if (((a >> 30) & 1) != 0) begin
      run = 30 - msb_of(~a & 64'h7FFF_FFFF);
      kv  = run - 1;
    end else begin
      run = 30 - msb_of(a);
      kv  = -run;
    end
    r    = (run >= 31) ? 0 : 30 - run;
    rest = a & ((64'd1 << r) - 1);
    if (r >= 3) begin
      f    = r - 3;
      e    = 3'(rest >> f);
      frac = rest & ((64'd1 << f) - 1);
    end else begin
      f    = 0;
      e    = 3'(rest << (3 - r));
      frac = 0;
    end
    kk = 6'(kv);
    m  = 32'(64'h8000_0000 | (frac << (31 - f)));
  endfunction

  // One request; returns one cycle after the done pulse.
  task automatic run_decode(input logic [31:0] w, input bit hold);
    logic s; logic [5:0] kk; logic [2:0] e; logic [31:0] m;
    int cyc;
    ref_model(w, s, kk, e, m);
    @(negedge clk);
    posit_num = w;
    start     = 1'b1;
    @(posedge clk); #1;
    if (!hold) start = 1'b0;
    posit_num = $urandom;
    cyc = 0;
    while (!done && cyc < 10) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("latency", 32'(cyc), 32'd3);
    if (hold && last_done >= 0) chk("period", 32'(cycle - last_done), 32'd5);
    last_done = cycle;
    chk("sign", 32'(sign), 32'(s));
    chk("k", 32'(k), 32'(kk));
    chk("exp", 32'(exp_value), 32'(e));
    chk("mant", mantissa, m);
    @(posedge clk); #1;
    chk("done_low", 32'(done), 32'd0);
    chk("k_hold", 32'(k), 32'(kk));
    chk("mant_hold", mantissa, m);
  endtask

  logic [31:0] w;

  initial begin
    posit_num = '0;
    start     = 1'b0;
    rst       = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_sign", 32'(sign), 32'd0);
    chk("rst_k", 32'(k), 32'd0);
    chk("rst_mant", mantissa, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // Known-answer word checked against literal values.
    run_decode(32'h0DCC_CCCC, 1'b1);
    start = 1'b0;
    chk("kat_k", 32'(k), 32'h3D);
    chk("kat_exp", 32'(exp_value), 32'd5);
    chk("kat_mant", mantissa, 32'hE666_6600);

    // Corners.
    run_decode(32'h4000_0000, 1'b0);
    run_decode(32'hC000_0000, 1'b0);
    run_decode(32'h0000_0000, 1'b0);
    chk("zero_mant", mantissa, 32'd0);
    run_decode(32'h8000_0000, 1'b0);
    chk("nar_sign", 32'(sign), 32'd1);
    chk("nar_mant", mantissa, 32'd0);
    run_decode(32'h7FFF_FFFF, 1'b0);
    chk("max_k", 32'(k), 32'd30);
    run_decode(32'h0000_0001, 1'b0);
    chk("min_k", 32'(k), 32'(6'h22));
    run_decode(32'h8000_0001, 1'b0);
    run_decode(32'hFFFF_FFFF, 1'b0);

    // Reset during REGIME aborts the decode.
    @(negedge clk);
    posit_num = 32'h7FFF_FFFF;
    start     = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    chk("abort_k", 32'(k), 32'd0);
    chk("abort_mant", mantissa, 32'd0);
    chk("abort_sign", 32'(sign), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    begin
      int seen = 0;
      for (int i = 0; i < 6; i++) begin
        @(posedge clk); #1;
        if (done) seen++;
      end
      chk("abort_nodone", 32'(seen), 32'd0);
    end
    last_done = -1;
    run_decode(32'h0DCC_CCCC, 1'b0);
    chk("restart_mant", mantissa, 32'hE666_6600);

    // Continuous start: back-to-back decodes every 5 cycles.
    last_done = -1;
    for (int i = 0; i < 6; i++) run_decode($urandom, 1'b1);
    start = 1'b0;

    // Randomized words, biased toward long regimes.
    last_done = -1;
    for (int i = 0; i < 40; i++) begin
      w = $urandom;
      if (i % 2 == 1) w = w >> $urandom_range(0, 31);
      if (i % 4 == 3) w = ~w;
      run_decode(w, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/posit_decoder.md
POSIT_DECODER -- requirements
Module: posit_decoder

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset; ports in order: posit_num, start, clk, rst, sign, done, k, exp_value, mantissa.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 posit_num  input  32  posit<32,3> word to decode.
REQ-005 start  input  1  request; sampled on clk edges in IDLE only.
REQ-006 sign  output  1  bit 31 of the captured word.
REQ-007 done  output  1  one-cycle pulse; outputs valid.
REQ-008 k  output  6  signed two's-complement regime value.
REQ-009 exp_value  output  3  unsigned exponent field (es=3).
REQ-010 mantissa  output  32  significand: hidden bit at [31], fraction left-aligned below it, zero-filled.

Function
REQ-011 SHALL implement the FSM IDLE -> ABS -> REGIME -> EXTRACT -> DONE -> IDLE, one state per clock.
REQ-012 IDLE: if start=1 at edge E0, SHALL capture posit_num and go to ABS; otherwise stay.
REQ-013 ABS: SHALL store sign=word[31] and replace the word with its two's complement when sign=1.
REQ-014 REGIME: SHALL count run length m of identical bits starting at bit 30 (stop at first opposite bit or bit 0).
REQ-015 Regime rule: k=m-1 for a run of ones, k=-m for a run of zeros; the result range is [-30,30].
REQ-016 EXTRACT: SHALL skip the run and the terminator bit, if present.
REQ-017 EXTRACT: SHALL take the next 3 bits as exp_value, padding with zeros where bits run out.
REQ-018 EXTRACT: SHALL set mantissa={1'b1, remaining bits left-aligned, zeros}.
REQ-019 DONE: done=1 for exactly one cycle (registered); done rises at edge E3 after the start-sampling edge E0.
REQ-020 sign/k/exp_value/mantissa SHALL hold from E3 until the next accepted start updates them.
REQ-021 start asserted outside IDLE SHALL be ignored.
REQ-022 Back-to-back: start still high in the IDLE cycle after DONE SHALL begin a new decode.
REQ-023 Zero (0x00000000) SHALL give sign=0, k=0, exp_value=0, mantissa=0.
REQ-024 NaR (0x80000000) SHALL give sign=1, k=0, exp_value=0, mantissa=0; the mantissa=0 hidden bit is the zero/NaR indicator.
REQ-025 A run reaching bit 0 with no terminator (e.g. 0x7FFFFFFF) SHALL give k=30, exp_value=0, mantissa=0x80000000.
REQ-026 posit_num SHALL be read only at the accepting edge; later changes SHALL NOT affect the result.

Reset
REQ-027 While rst=0, asynchronously: state=IDLE, done=0, sign=0, k=0, exp_value=0, mantissa=0, internal word cleared.
REQ-028 Reset asserted mid-decode SHALL abort it with no done pulse; operation SHALL resume with the first start sampled after rst rises.

Structure
REQ-029 A shared package SHALL hold N=32, ES=3, K_W=6, the state encoding, and the NAR/ZERO word constants.
REQ-030 Regime run counting SHALL be one combinational sub-module, posit_regime_counter (32-bit word in, run length and run polarity out).
REQ-031 The FSM, abs stage, and barrel-shift extraction SHALL reside in posit_decoder.

Verification
REQ-032 0x0DCCCCCC, start held until done -> sign=0, k=-3 (6'b111101), exp_value=5, mantissa=0xE6666600, done at E3.
REQ-033 0x40000000 -> sign=0, k=0, exp_value=0, mantissa=0x80000000; 0xC0000000 -> the same but sign=1.
REQ-034 0x00000000 -> all outputs 0; 0x80000000 -> sign=1, others 0.
REQ-035 0x7FFFFFFF -> k=30, exp_value=0, mantissa=0x80000000; 0x00000001 -> k=-30, exp_value=0, mantissa=0x80000000.
REQ-036 rst=0 asserted during REGIME -> outputs 0 immediately and no done pulse; restart with 0x0DCCCCCC -> REQ-032 results.
REQ-037 start held high continuously -> a done pulse every 5 cycles; posit_num changed after acceptance does not affect the result.
